// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter in front of a small 8-bit register bank.
// Define ARB_LOCK_EN to add a lock input that keeps the last grantee.
module reg_bank_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int GW    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef ARB_LOCK_EN
  input  logic              lock,
`endif
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [7:0]        rd_data,
  output logic              wr_strobe,
  output logic [GW-1:0]     wr_id,
  output logic [AW-1:0]     wr_addr_q
);

  if (NREQ < 2 || NREQ > 8 || GW != $clog2(NREQ)) begin : g_bad_nreq
    $error("reg_bank_write_arbiter: bad NREQ/GW");
  end
  if (DEPTH < 2 || DEPTH > 16 || AW != $clog2(DEPTH)
      || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("reg_bank_write_arbiter: bad DEPTH/AW");
  end

  logic [7:0]    bank_q [DEPTH];
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic          strobe_q, strobe_d;
  logic [GW-1:0] id_q, id_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          hi_found, lo_found;
  logic [GW-1:0] hi_idx, lo_idx;
  logic          lock_hit;
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic          grant;
  logic [AW-1:0] win_addr;
  logic [7:0]    win_data;

  // Split valid requesters into those above the pointer and the
  // wrap-around set; the lowest index of each set is kept.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = GW'(i);
        end
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign lock_hit = lock & req_valid[rr_ptr_q];
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    priority case (1'b1)
      lock_hit: begin
        win_found = 1'b1;
        win_idx   = rr_ptr_q;
      end
      hi_found: begin
        win_found = 1'b1;
        win_idx   = hi_idx;
      end
      lo_found: begin
        win_found = 1'b1;
        win_idx   = lo_idx;
      end
      default: ;
    endcase
  end

  // No grant may leak out while the block is held in reset.
  assign grant = win_found & reset_n;

  always_comb begin
    win_addr  = '0;
    win_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == win_idx) begin
        win_addr     = req_addr[i*AW +: AW];
        win_data     = req_data[i*8 +: 8];
        req_ready[i] = grant;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    strobe_d = grant;
    id_d     = id_q;
    addr_d   = addr_q;
    if (grant) begin
      rr_ptr_d = win_idx;
      id_d     = win_idx;
      addr_d   = win_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= GW'(NREQ - 1);
      strobe_q <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      strobe_q <= strobe_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        bank_q[j] <= 8'h00;
      end
    end else if (grant) begin
      bank_q[win_addr] <= win_data;
    end
  end

  assign rd_data   = bank_q[rd_addr];
  assign wr_strobe = strobe_q;
  assign wr_id     = id_q;
  assign wr_addr_q = addr_q;

endmodule

// File: doc/reg_bank_write_arbiter.md
Name: reg_bank_write_arbiter

Overview:
Shares a small bank of 8-bit storage registers between NREQ independent writers. Each clock, at most one write is granted, chosen by round-robin. The register bank (clocked 8-bit D registers) lives inside this block. Exposes one combinational read port and a registered write-commit status. Sits between the requester logic and the stored-state datapath.

Parameters:
NREQ, 4, number of write requesters (2..8)
DEPTH, 4, number of 8-bit registers in the bank (power of two, 2..16)
AW, 2, address width; must equal log2(DEPTH)
GW, 2, grant-id width; must equal ceil(log2(NREQ))

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous reset, active-low
req_valid  in  NREQ  bit i: requester i has a write pending
req_addr  in  NREQ*AW  requester i address in slice [i*AW +: AW]
req_data  in  NREQ*8  requester i data in slice [i*8 +: 8]
req_ready  out  NREQ  one-hot grant, combinational; write occurs when req_valid[i] & req_ready[i]
rd_addr  in  AW  read address
rd_data  out  8  bank[rd_addr], combinational read of registered contents
wr_strobe  out  1  registered; 1 for exactly one cycle after each committed write
wr_id  out  GW  registered; index of the requester whose write committed last
wr_addr_q  out  AW  registered; address of the last committed write

Behaviour:
- Reset (reset_n low, asynchronous): all bank entries 8'h00, rr_ptr = NREQ-1 (requester 0 has first priority), wr_strobe 0, wr_id 0, wr_addr_q 0. req_ready is all zero while reset_n is low.
- Arbitration (combinational): search starts at (rr_ptr+1) mod NREQ and wraps upward. The first i with req_valid[i]=1 wins. req_ready = one-hot(winner). If no requester is valid, req_ready = 0.
- req_ready[i] never asserts without req_valid[i]. At most one bit is set per cycle.
- Commit (rising edge with a winner): bank[winner addr] <= winner data; rr_ptr <= winner; wr_strobe <= 1; wr_id <= winner; wr_addr_q <= winner addr.
- Idle edge (no winner): bank and rr_ptr hold; wr_strobe <= 0; wr_id and wr_addr_q hold.
- Latency: the written value is visible on rd_data in the cycle after the commit edge. The grant is given in the same cycle as the request (zero-wait when uncontended).
- Read-during-write: rd_data shows the old value in the commit cycle and the new value from the next cycle.
- Fairness: with all NREQ continuously valid, grants rotate 0,1,...,NREQ-1,0. Any continuously valid requester waits at most NREQ-1 cycles.
- A requester may hold req_valid across cycles. Each cycle it is granted counts as one independent write.
- Multiple requesters to the same address: only the winner writes that cycle. Losers retry on later cycles, so the last writer wins.
- Reset asserted mid-operation: the bank clears immediately and any in-flight grant is discarded. The first grant after release goes to requester 0 if it is valid.

Optional Feature:
ARB_LOCK_EN
- Defined: adds input port lock (1 bit). If lock=1 and the requester equal to rr_ptr (the last grantee) has req_valid=1, that requester wins regardless of rotation and rr_ptr does not change. This allows back-to-back burst writes. If lock=1 but that requester is not valid, normal round-robin applies.
- Undefined: no lock port; pure round-robin as above.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles then 1, all req_valid=0 -> bank all 8'h00, req_ready=0, wr_strobe=0, rd_data=8'h00 for every rd_addr.
- Single write: req_valid=4'b0100, req2 addr=3, data=8'hA5 -> req_ready=4'b0100 same cycle; next cycle wr_strobe=1, wr_id=2, wr_addr_q=3, rd_data(rd_addr=3)=8'hA5.
- Full contention: req_valid=4'b1111 for 5 cycles, req i data=8'h10+i to addr i -> grant order 0,1,2,3,0; bank = 10,11,12,13.
- Same-address collision: req1 (8'h11) and req3 (8'h33) both to addr 0, rr_ptr=1 -> req3 wins first, then req1; final bank[0]=8'h11.
- Async reset mid-burst: assert reset_n=0 between edges while req_valid=4'b1111 -> bank reads 8'h00 immediately, req_ready=0. After release, first grant goes to req0.
- ARB_LOCK_EN: lock=1, req_valid=4'b0011, req0 granted first -> req0 granted for 3 consecutive cycles. Drop lock -> next grant goes to req1.
